// File: rtl/branch_resolver_if.sv
// Bus between fetch and the branch resolver: flag writes, request, result and statistics.
interface branch_resolver_if #(
  parameter int PC_WIDTH  = 16,
  parameter int BW        = 1,
  parameter int CNT_WIDTH = 16
);
  logic                 flag_we;
  logic [BW-1:0]        flag_wbank;
  logic [3:0]           flags_in;
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           op_tf;
  logic [2:0]           cond;
  logic [BW-1:0]        flag_rbank;
  logic [PC_WIDTH-1:0]  pc_plus1;
  logic [PC_WIDTH-1:0]  target;
  logic [PC_WIDTH-1:0]  reg_b;
  logic                 flush;
  logic                 res_valid;
  logic                 res_ready;
  logic                 taken;
  logic [PC_WIDTH-1:0]  next_pc;
  logic                 link_we;
  logic [PC_WIDTH-1:0]  link_pc;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] taken_cnt;
  logic [CNT_WIDTH-1:0] ntaken_cnt;

  modport master (
    output flag_we, flag_wbank, flags_in, req_valid, op_tf, cond, flag_rbank,
           pc_plus1, target, reg_b, flush, res_ready,
    input  req_ready, res_valid, taken, next_pc, link_we, link_pc, illegal,
           taken_cnt, ntaken_cnt
  );

  modport slave (
    input  flag_we, flag_wbank, flags_in, req_valid, op_tf, cond, flag_rbank,
           pc_plus1, target, reg_b, flush, res_ready,
    output req_ready, res_valid, taken, next_pc, link_we, link_pc, illegal,
           taken_cnt, ntaken_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: banked O/S/C/Z flag registers, one-cycle branch evaluation,
// valid/ready result towards fetch and saturating taken/not-taken statistics.
module branch_resolver #(
  parameter int PC_WIDTH  = 16,
  parameter int NUM_BANKS = 2,
  parameter int BYPASS    = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  branch_resolver_if.slave bus
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [2:0] {
    OP_JF    = 3'b000,
    OP_JT    = 3'b001,
    OP_J     = 3'b010,
    OP_JAL   = 3'b011,
    OP_JR    = 3'b100,
    OP_NEVER = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    C_TRUE    = 3'b000,
    C_NEG     = 3'b001,
    C_ZERO    = 3'b010,
    C_CARRY   = 3'b100,
    C_NEGZERO = 3'b101,
    C_OVF     = 3'b111
  } cond_e;

  logic [3:0]           r_bank [NUM_BANKS];
  logic                 r_res_valid;
  logic                 r_taken;
  logic [PC_WIDTH-1:0]  r_next_pc;
  logic                 r_link_we;
  logic [PC_WIDTH-1:0]  r_link_pc;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_taken_cnt;
  logic [CNT_WIDTH-1:0] r_ntaken_cnt;

  logic [3:0]           w_rd_flags;
  logic                 w_rd_valid;
  logic [3:0]           w_eval;
  logic                 w_c;
  logic                 w_cond_ill;
  logic                 w_taken;
  logic [PC_WIDTH-1:0]  w_next_pc;
  logic                 w_link;
  logic                 w_illegal;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_deliver;

  assign w_req_ready = !bus.flush && (!r_res_valid || bus.res_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_deliver   = r_res_valid && bus.res_ready && !bus.flush;

  // Bank read with out-of-range banks returning zero, plus optional write forwarding.
  always_comb begin
    w_rd_flags = '0;
    w_rd_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (bus.flag_rbank == BW'(i)) begin
        w_rd_flags = r_bank[i];
        w_rd_valid = 1'b1;
      end
    end
    w_eval = w_rd_flags;
    if ((BYPASS != 0) && bus.flag_we && w_rd_valid && (bus.flag_wbank == bus.flag_rbank))
      w_eval = bus.flags_in;
  end

  // Condition and branch-type decode; flags are {O,S,C,Z}.
  always_comb begin
    w_c        = 1'b0;
    w_cond_ill = 1'b0;
    case (cond_e'(bus.cond))
      C_TRUE:    w_c = 1'b1;
      C_NEG:     w_c = w_eval[2];
      C_ZERO:    w_c = w_eval[0];
      C_CARRY:   w_c = w_eval[1];
      C_NEGZERO: w_c = w_eval[2] | w_eval[0];
      C_OVF:     w_c = w_eval[3];
      default:   w_cond_ill = 1'b1;
    endcase

    w_taken   = 1'b0;
    w_next_pc = bus.pc_plus1;
    w_link    = 1'b0;
    w_illegal = w_cond_ill;
    case (op_e'(bus.op_tf))
      OP_NEVER: w_taken = 1'b0;
      OP_JF:    w_taken = !w_c;
      OP_JT:    w_taken = w_c;
      OP_J:     w_taken = 1'b1;
      OP_JAL:   begin w_taken = 1'b1; w_link = 1'b1; end
      OP_JR:    w_taken = 1'b1;
      default:  w_illegal = 1'b1;
    endcase
    if (w_taken)
      w_next_pc = ((op_e'(bus.op_tf) == OP_JAL) || (op_e'(bus.op_tf) == OP_JR)) ? bus.reg_b : bus.target;
  end

  // Flag banks, result registers and statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) r_bank[i] <= '0;
      r_res_valid  <= 1'b0;
      r_taken      <= 1'b0;
      r_next_pc    <= '0;
      r_link_we    <= 1'b0;
      r_link_pc    <= '0;
      r_illegal    <= 1'b0;
      r_taken_cnt  <= '0;
      r_ntaken_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BANKS; i++)
        if (bus.flag_we && (bus.flag_wbank == BW'(i))) r_bank[i] <= bus.flags_in;

      // link_we only ever describes a held jal, so it drops whenever the slot empties
      if (bus.flush) begin
        r_res_valid <= 1'b0;
        r_link_we   <= 1'b0;
      end else if (w_accept) begin
        r_res_valid <= 1'b1;
        r_taken     <= w_taken;
        r_next_pc   <= w_next_pc;
        r_link_we   <= w_link;
        r_illegal   <= w_illegal;
        if (w_link) r_link_pc <= bus.pc_plus1;
      end else if (w_deliver) begin
        r_res_valid <= 1'b0;
        r_link_we   <= 1'b0;
      end

      if (w_deliver) begin
        if (r_taken) begin
          if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
        end else begin
          if (r_ntaken_cnt != '1) r_ntaken_cnt <= r_ntaken_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.taken      = r_taken;
  assign bus.next_pc    = r_next_pc;
  assign bus.link_we    = r_link_we;
  assign bus.link_pc    = r_link_pc;
  assign bus.illegal    = r_illegal;
  assign bus.taken_cnt  = r_taken_cnt;
  assign bus.ntaken_cnt = r_ntaken_cnt;
endmodule

// File: tb/tb_branch_resolver.sv
// Bench: three resolvers share one stimulus stream -- default, no bypass,
// and a 3-bank / 2-bit-counter variant for range and saturation corners.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_flag_we, t_req_valid, t_flush, t_res_ready;
  logic [1:0]  t_wbank, t_rbank;
  logic [3:0]  t_flags;
  logic [2:0]  t_op, t_cond;
  logic [15:0] t_pc1, t_tgt, t_regb;

  branch_resolver_if #(.PC_WIDTH(16), .BW(1), .CNT_WIDTH(16)) if0 ();
  branch_resolver_if #(.PC_WIDTH(16), .BW(1), .CNT_WIDTH(16)) if1 ();
  branch_resolver_if #(.PC_WIDTH(16), .BW(2), .CNT_WIDTH(2))  if2 ();

  assign if0.flag_we = t_flag_we;      assign if1.flag_we = t_flag_we;      assign if2.flag_we = t_flag_we;
  assign if0.flag_wbank = t_wbank[0];  assign if1.flag_wbank = t_wbank[0];  assign if2.flag_wbank = t_wbank;
  assign if0.flags_in = t_flags;       assign if1.flags_in = t_flags;       assign if2.flags_in = t_flags;
  assign if0.req_valid = t_req_valid;  assign if1.req_valid = t_req_valid;  assign if2.req_valid = t_req_valid;
  assign if0.op_tf = t_op;             assign if1.op_tf = t_op;             assign if2.op_tf = t_op;
  assign if0.cond = t_cond;            assign if1.cond = t_cond;            assign if2.cond = t_cond;
  assign if0.flag_rbank = t_rbank[0];  assign if1.flag_rbank = t_rbank[0];  assign if2.flag_rbank = t_rbank;
  assign if0.pc_plus1 = t_pc1;         assign if1.pc_plus1 = t_pc1;         assign if2.pc_plus1 = t_pc1;
  assign if0.target = t_tgt;           assign if1.target = t_tgt;           assign if2.target = t_tgt;
  assign if0.reg_b = t_regb;           assign if1.reg_b = t_regb;           assign if2.reg_b = t_regb;
  assign if0.flush = t_flush;          assign if1.flush = t_flush;          assign if2.flush = t_flush;
  assign if0.res_ready = t_res_ready;  assign if1.res_ready = t_res_ready;  assign if2.res_ready = t_res_ready;

  branch_resolver #(.PC_WIDTH(16), .NUM_BANKS(2), .BYPASS(1), .CNT_WIDTH(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  branch_resolver #(.PC_WIDTH(16), .NUM_BANKS(2), .BYPASS(0), .CNT_WIDTH(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  branch_resolver #(.PC_WIDTH(16), .NUM_BANKS(3), .BYPASS(1), .CNT_WIDTH(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  cond;
    logic [3:0]  flags;
    logic        e_taken;
    logic [15:0] e_pc;
    logic        e_link;
    logic        e_ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    t_flag_we = 0; t_req_valid = 0; t_flush = 0; t_res_ready = 1;
    t_wbank = 0; t_rbank = 0; t_flags = 0; t_op = 3'b111; t_cond = 0;
    t_pc1 = 16'h0011; t_tgt = 16'h2000; t_regb = 16'h0040;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".res_valid"}, if0.res_valid, 0);
    chk({tag, ".taken"}, if0.taken, 0);
    chk({tag, ".next_pc"}, if0.next_pc, 0);
    chk({tag, ".link_we"}, if0.link_we, 0);
    chk({tag, ".link_pc"}, if0.link_pc, 0);
    chk({tag, ".illegal"}, if0.illegal, 0);
    chk({tag, ".taken_cnt"}, if0.taken_cnt, 0);
    chk({tag, ".ntaken_cnt"}, if0.ntaken_cnt, 0);
    chk({tag, ".cnt2"}, {if2.taken_cnt, if2.ntaken_cnt}, 0);
  endtask

  // Independent reference for the exhaustive sweep; flags are {O,S,C,Z}.
  function automatic logic model_taken(input logic [2:0] op, input logic [2:0] cnd, input logic [3:0] f);
    logic c;
    c = (cnd == 3'd0) ? 1'b1 :
        (cnd == 3'd1) ? f[2] :
        (cnd == 3'd2) ? f[0] :
        (cnd == 3'd4) ? f[1] :
        (cnd == 3'd5) ? (f[2] | f[0]) :
        (cnd == 3'd7) ? f[3] : 1'b0;
    if (op == 3'd0) return !c;
    if (op == 3'd1) return c;
    return (op == 3'd2 || op == 3'd3 || op == 3'd4);
  endfunction

  vec_t vt[16];
  logic [2:0] ops[6];
  logic [2:0] conds[6];

  initial begin
    // pc_plus1=0011, target=2000, reg_b=0040 for every table row
    vt[0]  = '{3'b111, 3'b000, 4'b0000, 0, 16'h0011, 0, 0};
    vt[1]  = '{3'b000, 3'b000, 4'b0000, 0, 16'h0011, 0, 0};
    vt[2]  = '{3'b001, 3'b010, 4'b0001, 1, 16'h2000, 0, 0};
    vt[3]  = '{3'b001, 3'b010, 4'b0000, 0, 16'h0011, 0, 0};
    vt[4]  = '{3'b000, 3'b010, 4'b0000, 1, 16'h2000, 0, 0};
    vt[5]  = '{3'b001, 3'b100, 4'b0010, 1, 16'h2000, 0, 0};
    vt[6]  = '{3'b001, 3'b101, 4'b0100, 1, 16'h2000, 0, 0};
    vt[7]  = '{3'b001, 3'b101, 4'b0010, 0, 16'h0011, 0, 0};
    vt[8]  = '{3'b001, 3'b111, 4'b1000, 1, 16'h2000, 0, 0};
    vt[9]  = '{3'b000, 3'b111, 4'b1000, 0, 16'h0011, 0, 0};
    vt[10] = '{3'b010, 3'b000, 4'b0000, 1, 16'h2000, 0, 0};
    vt[11] = '{3'b011, 3'b000, 4'b0000, 1, 16'h0040, 1, 0};
    vt[12] = '{3'b100, 3'b000, 4'b0000, 1, 16'h0040, 0, 0};
    vt[13] = '{3'b101, 3'b000, 4'b1111, 0, 16'h0011, 0, 1};
    vt[14] = '{3'b001, 3'b011, 4'b1111, 0, 16'h0011, 0, 1};
    vt[15] = '{3'b001, 3'b001, 4'b0100, 1, 16'h2000, 0, 0};
    ops   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    conds = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7};

    idle();
    rst_n = 1;
    tick();
    do_reset();
    chk_reset_state("reset");
    chk("reset.req_ready", if0.req_ready, 1);

    // Directed table: load bank 0, then request from bank 0 with writes idle.
    for (int i = 0; i < 16; i++) begin
      t_flag_we = 1; t_wbank = 0; t_flags = vt[i].flags; t_req_valid = 0;
      tick();
      t_flag_we = 0; t_req_valid = 1; t_op = vt[i].op; t_cond = vt[i].cond;
      tick();
      t_req_valid = 0;
      chk($sformatf("vec%0d.valid", i), if0.res_valid, 1);
      chk($sformatf("vec%0d.taken", i), if0.taken, vt[i].e_taken);
      chk($sformatf("vec%0d.next_pc", i), if0.next_pc, vt[i].e_pc);
      chk($sformatf("vec%0d.link_we", i), if0.link_we, vt[i].e_link);
      chk($sformatf("vec%0d.illegal", i), if0.illegal, vt[i].e_ill);
      chk($sformatf("vec%0d.nobypass_taken", i), if1.taken, vt[i].e_taken);
      if (vt[i].e_link) chk($sformatf("vec%0d.link_pc", i), if0.link_pc, 16'h0011);
    end

    // Exhaustive sweep over legal op_tf x legal cond x flag values.
    for (int o = 0; o < 6; o++)
      for (int c = 0; c < 6; c++)
        for (int f = 0; f < 16; f++) begin
          t_flag_we = 1; t_wbank = 0; t_flags = 4'(f); t_req_valid = 0;
          tick();
          t_flag_we = 0; t_req_valid = 1; t_op = ops[o]; t_cond = conds[c];
          t_pc1 = 16'h0100 + 16'(f);
          tick();
          t_req_valid = 0;
          chk($sformatf("sweep op%0d c%0d f%0h taken", ops[o], conds[c], f), if0.taken,
              model_taken(ops[o], conds[c], 4'(f)));
          chk($sformatf("sweep op%0d c%0d f%0h pc", ops[o], conds[c], f), if0.next_pc,
              model_taken(ops[o], conds[c], 4'(f)) ? ((ops[o] == 3'd3 || ops[o] == 3'd4) ? 16'h0040 : 16'h2000)
                                                   : 16'h0100 + 16'(f));
        end

    // Same-cycle flag write forwarding (C=1), and the write landing in the bank.
    idle(); do_reset();
    t_flag_we = 1; t_wbank = 0; t_flags = 4'b0010;
    t_req_valid = 1; t_op = 3'b001; t_cond = 3'b100; t_rbank = 0;
    tick();
    chk("bypass.on", if0.taken, 1);
    chk("bypass.off", if1.taken, 0);
    t_flag_we = 0;
    tick();
    t_req_valid = 0;
    chk("bypass.off_later", if1.taken, 1);

    // Bank range on the 3-bank resolver: bank 3 ignored on write and reads 0000.
    idle(); do_reset();
    t_flag_we = 1; t_wbank = 2'd3; t_flags = 4'b0001; tick();
    t_wbank = 2'd2; tick();
    t_flag_we = 0; t_req_valid = 1; t_op = 3'b001; t_cond = 3'b010; t_rbank = 2'd3;
    tick();
    chk("range.bank3", if2.taken, 0);
    t_rbank = 2'd2;
    tick();
    t_req_valid = 0;
    chk("range.bank2", if2.taken, 1);

    // Stall: result held for 3 cycles with res_ready low, then one delivery.
    idle(); do_reset();
    t_req_valid = 1; t_op = 3'b011; t_pc1 = 16'h0011; t_regb = 16'h0040;
    tick();
    t_res_ready = 0; t_op = 3'b010; t_tgt = 16'h1234; t_pc1 = 16'h0077;
    #1;
    chk("stall.req_ready_now", if0.req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d.req_ready", k), if0.req_ready, 0);
      chk($sformatf("stall%0d.hold", k), {if0.res_valid, if0.taken, if0.link_we}, 3'b111);
      chk($sformatf("stall%0d.next_pc", k), if0.next_pc, 16'h0040);
      chk($sformatf("stall%0d.link_pc", k), if0.link_pc, 16'h0011);
      chk($sformatf("stall%0d.cnt", k), if0.taken_cnt, 0);
    end
    t_res_ready = 1; t_req_valid = 0;
    tick();
    chk("stall.done_valid", if0.res_valid, 0);
    chk("stall.done_link_we", if0.link_we, 0);
    chk("stall.taken_cnt", if0.taken_cnt, 1);
    chk("stall.ntaken_cnt", if0.ntaken_cnt, 0);

    // Flush with a held result and a pending request.
    idle(); do_reset();
    t_req_valid = 1; t_op = 3'b010;
    tick();
    t_flush = 1;
    #1;
    chk("flush.req_ready", if0.req_ready, 0);
    tick();
    chk("flush.res_valid", if0.res_valid, 0);
    chk("flush.cnts", {if0.taken_cnt, if0.ntaken_cnt}, 0);
    t_flush = 0; t_req_valid = 0;
    tick();
    chk("flush.no_accept", if0.res_valid, 0);
    chk("flush.cnts_after", {if0.taken_cnt, if0.ntaken_cnt}, 0);

    // Saturation: 5 taken deliveries, then one illegal delivery counted as not taken.
    idle(); do_reset();
    t_req_valid = 1; t_op = 3'b010;
    repeat (5) tick();
    t_req_valid = 0;
    tick();
    chk("sat.cnt16", if0.taken_cnt, 5);
    chk("sat.cnt2", if2.taken_cnt, 2'd3);
    t_req_valid = 1; t_op = 3'b101;
    tick();
    t_req_valid = 0;
    chk("illegal.flag", {if0.illegal, if0.taken}, 2'b10);
    chk("illegal.next_pc", if0.next_pc, 16'h0011);
    tick();
    chk("illegal.ntaken_cnt", if0.ntaken_cnt, 1);
    chk("illegal.taken_cnt", if0.taken_cnt, 5);

    // Reset in the middle of a stall; banks cleared as well.
    idle(); do_reset();
    t_flag_we = 1; t_wbank = 0; t_flags = 4'b0001;
    tick();
    t_flag_we = 0; t_req_valid = 1; t_op = 3'b011; t_pc1 = 16'h0055;
    tick();
    t_res_ready = 0; t_req_valid = 0;
    tick();
    do_reset();
    chk_reset_state("midreset");
    t_res_ready = 1; t_req_valid = 1; t_op = 3'b001; t_cond = 3'b010; t_rbank = 0;
    tick();
    t_req_valid = 0;
    chk("midreset.bank_cleared", if0.taken, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
